// File: rtl/timer_defs_pkg.sv
// timer_defs: shared state encoding, default timing constants and BCD helpers for the countdown timer
package timer_defs;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_EXPIRED
    } state_e;

    localparam int DEF_TICK_DIV    = 50_000_000;
    localparam int DEF_PRESET_SEC  = 30;
    localparam int DEF_BEEP_CYCLES = 25_000_000;
    localparam int BCD_W           = 4;

    // Elaboration-time split of a 0..99 value into {tens, ones}; never used on runtime data.
    function automatic logic [2*BCD_W-1:0] to_bcd(input int v);
        return {BCD_W'(v / 10), BCD_W'(v % 10)};
    endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: one-second prescaler that pulses tick on its last count while enabled and holds its count when disabled
module tick_gen
    import timer_defs::*;
#(
    parameter int DIV = DEF_TICK_DIV
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == W'(DIV - 1));

    // Clear wins over counting; a disabled prescaler freezes so a paused run resumes mid-second.
    always_comb begin
        cnt_d = clr ? '0 : !en ? cnt_q : tick ? '0 : cnt_q + 1'b1;
    end

    // Prescaler count register.
    always_ff @(posedge CLK) begin
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: BCD seconds countdown with run/pause control, expiry lockout and a timed buzzer
module countdown_timer
    import timer_defs::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int PRESET_SEC  = DEF_PRESET_SEC,
    parameter int BEEP_CYCLES = DEF_BEEP_CYCLES
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Timer_Start,
    input  logic             Clear,
    output logic [BCD_W-1:0] Time_Tens,
    output logic [BCD_W-1:0] Time_Ones,
    output logic             Block_Sel,
    output logic             Beep_Enable,
    output logic             Running
);

    localparam logic [2*BCD_W-1:0] PRESET_BCD = to_bcd(PRESET_SEC);
    localparam logic [BCD_W-1:0]   PRE_TENS   = PRESET_BCD[2*BCD_W-1:BCD_W];
    localparam logic [BCD_W-1:0]   PRE_ONES   = PRESET_BCD[BCD_W-1:0];
    localparam int                 BW         = $clog2(BEEP_CYCLES + 1);

    state_e           state_q, state_d;
    logic [BCD_W-1:0] tens_q, tens_d, ones_q, ones_d;
    logic             block_q, block_d, beep_q, beep_d, run_q, run_d;
    logic [BW-1:0]    beep_cnt_q, beep_cnt_d;
    logic             tick, run_en, clr;

    // Prescaler only advances while actually counting; it is held at zero in IDLE and on Clear.
    assign run_en = (state_q == ST_RUN) && Timer_Start && !Clear;
    assign clr    = Clear || (state_q == ST_IDLE);

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .CLK (CLK),
        .RST (RST),
        .clr (clr),
        .en  (run_en),
        .tick(tick)
    );

    // Next-state and next-output logic: Clear overrides everything, then run/hold, then the tick.
    always_comb begin
        state_d    = state_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        block_d    = block_q;
        beep_d     = beep_q;
        beep_cnt_d = beep_cnt_q;
        if (Clear) begin
            state_d    = ST_IDLE;
            tens_d     = PRE_TENS;
            ones_d     = PRE_ONES;
            block_d    = 1'b0;
            beep_d     = 1'b0;
            beep_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tens_d  = PRE_TENS;
                    ones_d  = PRE_ONES;
                    state_d = Timer_Start ? ST_RUN : ST_IDLE;
                end
                ST_RUN: begin
                    if (!Timer_Start) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        if (tens_q == '0 && ones_q == BCD_W'(1)) begin
                            ones_d     = '0;
                            state_d    = ST_EXPIRED;
                            block_d    = 1'b1;
                            beep_d     = 1'b1;
                            beep_cnt_d = '0;
                        end else begin
                            ones_d = (ones_q == '0) ? BCD_W'(9) : ones_q - 1'b1;
                            tens_d = (ones_q == '0) ? tens_q - 1'b1 : tens_q;
                        end
                    end
                end
                ST_PAUSE: begin
                    state_d = Timer_Start ? ST_RUN : ST_PAUSE;
                end
                ST_EXPIRED: begin
                    if (beep_q) begin
                        beep_d     = (beep_cnt_q != BW'(BEEP_CYCLES - 1));
                        beep_cnt_d = beep_d ? beep_cnt_q + 1'b1 : beep_cnt_q;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        run_d = (state_d == ST_RUN);
    end

    // State and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            tens_q     <= PRE_TENS;
            ones_q     <= PRE_ONES;
            block_q    <= 1'b0;
            beep_q     <= 1'b0;
            beep_cnt_q <= '0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            block_q    <= block_d;
            beep_q     <= beep_d;
            beep_cnt_q <= beep_cnt_d;
            run_q      <= run_d;
        end
    end

    assign Time_Tens   = tens_q;
    assign Time_Ones   = ones_q;
    assign Block_Sel   = block_q;
    assign Beep_Enable = beep_q;
    assign Running     = run_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard bench comparing the timer against an integer-seconds reference model
module tb_countdown_timer;

    localparam int TD = 4;
    localparam int PS = 12;
    localparam int BC = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       Timer_Start = 1'b0;
    logic       Clear = 1'b0;
    logic [3:0] Time_Tens, Time_Ones;
    logic       Block_Sel, Beep_Enable, Running;

    countdown_timer #(.TICK_DIV(TD), .PRESET_SEC(PS), .BEEP_CYCLES(BC)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Timer_Start(Timer_Start),
        .Clear      (Clear),
        .Time_Tens  (Time_Tens),
        .Time_Ones  (Time_Ones),
        .Block_Sel  (Block_Sel),
        .Beep_Enable(Beep_Enable),
        .Running    (Running)
    );

    always #5 CLK = ~CLK;

    // Reference model: remaining seconds as an integer, mode 0 idle / 1 run / 2 pause / 3 expired.
    int mode = 0;
    int rem  = PS;
    int pre  = 0;
    int bl   = 0;

    logic [10:0] exp_q[$];
    logic [10:0] want, got;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic model_step(input logic r, input logic s, input logic c);
        if (r || c) begin
            mode = 0; rem = PS; pre = 0; bl = 0;
        end else if (mode == 0) begin
            pre = 0;
            if (s) mode = 1;
        end else if (mode == 1) begin
            if (!s) mode = 2;
            else if (pre == TD - 1) begin
                pre = 0;
                rem = rem - 1;
                if (rem == 0) begin
                    mode = 3;
                    bl = BC;
                end
            end else pre = pre + 1;
        end else if (mode == 2) begin
            if (s) mode = 1;
        end else if (bl > 0) begin
            bl = bl - 1;
        end
    endtask

    function automatic logic [10:0] model_out();
        return {4'(rem / 10), 4'(rem % 10), mode == 3, mode == 3 && bl > 0, mode == 1};
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the following rising edge.
    task automatic drive(input logic r, input logic s, input logic c);
        @(negedge CLK);
        RST = r;
        Timer_Start = s;
        Clear = c;
        model_step(r, s, c);
        exp_q.push_back(model_out());
    endtask

    // Monitor: after each rising edge, compare the registered outputs with the oldest expectation.
    always @(posedge CLK) begin
        #1;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {Time_Tens, Time_Ones, Block_Sel, Beep_Enable, Running};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL outputs t=%0t got tens=%0d ones=%0d blk=%0b beep=%0b run=%0b want tens=%0d ones=%0d blk=%0b beep=%0b run=%0b",
                         $time, got[10:7], got[6:3], got[2], got[1], got[0],
                         want[10:7], want[6:3], want[2], want[1], want[0]);
            end
        end
    end

    initial begin
        repeat (2) drive(1, 0, 0);
        repeat (2) drive(0, 0, 0);
        repeat (60) drive(0, 1, 0);
        drive(0, 0, 1);
        repeat (22) drive(0, 1, 0);
        repeat (10) drive(0, 0, 0);
        repeat (6) drive(0, 1, 0);
        drive(1, 1, 0);
        repeat (3) drive(0, 1, 1);
        repeat (5) drive(0, 1, 0);
        drive(0, 0, 1);
        repeat (50) drive(0, 1, 0);
        drive(0, 0, 1);
        repeat (8) drive(0, 1, 0);
        drive(1, 0, 0);
        for (int i = 0; i < 3000; i++)
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 99) == 0);
        @(posedge CLK);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000, CLK cycles per one-second tick (range 2..2^26).
REQ-002 SHALL have parameter PRESET_SEC, default 30, countdown start value in seconds (range 1..99).
REQ-003 SHALL have parameter BEEP_CYCLES, default 25_000_000, timeout buzzer duration in CLK cycles (range 1..2^26).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 CLK  input  1  system clock; all state changes on rising edge.
REQ-006 RST  input  1  synchronous active-high reset.
REQ-007 Timer_Start  input  1  run-enable level from the selector block; high = count, low = hold.
REQ-008 Clear  input  1  host re-arm, sampled level; reloads preset.
REQ-009 Time_Tens  output  4  BCD tens digit of remaining seconds.
REQ-010 Time_Ones  output  4  BCD ones digit of remaining seconds.
REQ-011 Block_Sel  output  1  high = time expired; selector must ignore player keys.
REQ-012 Beep_Enable  output  1  timeout buzzer drive.
REQ-013 Running  output  1  high while in RUN.

Function
REQ-014 SHALL implement states IDLE, RUN, PAUSE, EXPIRED; all outputs registered.
REQ-015 IDLE: digits = PRESET_SEC; prescaler = 0; Timer_Start=1 -> RUN next edge.
REQ-016 RUN: prescaler counts 0..TICK_DIV-1; tick when prescaler = TICK_DIV-1 with Timer_Start=1; prescaler wraps to 0.
REQ-017 First decrement SHALL occur exactly TICK_DIV cycles after the edge entering RUN from IDLE.
REQ-018 On tick, BCD decrement: ones>0 -> ones-1; ones=0 -> ones=9, tens-1; digits never leave 0..9.
REQ-019 Tick with digits = 01 -> digits 00, state EXPIRED, Block_Sel=1, Beep_Enable=1, all on the same edge.
REQ-020 RUN with Timer_Start=0 -> PAUSE next edge; no decrement that cycle even if prescaler = TICK_DIV-1.
REQ-021 PAUSE: digits and prescaler frozen; Timer_Start=1 -> RUN, prescaler resumes from held value.
REQ-022 EXPIRED: digits 00, Block_Sel=1; Beep_Enable high exactly BEEP_CYCLES cycles from entry, then 0; Timer_Start ignored.
REQ-023 Clear=1 in any state -> IDLE next edge: digits = PRESET_SEC, Block_Sel=0, Beep_Enable=0, prescaler=0, beep counter=0.
REQ-024 Priority SHALL be RST > Clear > Timer_Start > tick.
REQ-025 Clear held high SHALL keep IDLE; RUN entered only on the first edge where Clear=0 and Timer_Start=1.
REQ-026 Running = 1 exactly when state = RUN.

Reset
REQ-027 RST=1 at a rising edge SHALL force IDLE, digits = PRESET_SEC, Block_Sel=0, Beep_Enable=0, Running=0, prescaler and beep counter 0, including mid-RUN or mid-beep.
REQ-028 First RUN entry after RST deasserts SHALL require Timer_Start=1 sampled with RST=0.

Structure
REQ-029 State encoding, default TICK_DIV/PRESET_SEC/BEEP_CYCLES and BCD width constant SHALL live in shared include timer_defs.
REQ-030 Prescaler SHALL be one sub-module, tick_gen (inputs CLK, RST, clr, en; output tick; parameter DIV).
REQ-031 Preset SHALL be split into tens/ones at elaboration; no runtime divider.

Verification
REQ-032 TICK_DIV=4, PRESET_SEC=12, BEEP_CYCLES=3: Timer_Start=1 held -> digits 12,11,10,09,…,01,00 every 4 cycles; Block_Sel=1 at 00; Beep_Enable high exactly 3 cycles.
REQ-033 In RUN at 07, Timer_Start=0 on prescaler = 3 -> PAUSE, digits stay 07; Timer_Start=1 after 10 cycles -> 06 after 1 more cycle.
REQ-034 PRESET_SEC=10: tick at 10 -> 09 (ones wrap, tens decrement); PRESET_SEC=1 -> EXPIRED 4 cycles after RUN entry.
REQ-035 In EXPIRED mid-beep, Clear=1 one cycle -> Beep_Enable=0, Block_Sel=0, digits 12, IDLE; Timer_Start=1 restarts count.
REQ-036 RST=1 at digits 05 in RUN -> next edge digits 12, Running=0; Clear and Timer_Start=1 together -> stays IDLE.
